// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a small receive FIFO.
// rx_i must already be synchronised to clk_i; frame/overflow errors are one-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB < 2) ? 1 : $clog2(CPB);
    localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    generate
        if (CPB < 2) begin : g_cpb_chk
            $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
            $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             prev_rx_r;
    logic             push_s, ferr_s;
    logic             frame_err_r, overflow_r, busy_r;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [OCC_W-1:0] count_r, count_s;
    logic [7:0]       data_r, data_s;
    logic             valid_r;
    logic             pop_s, full_s, push_ok_s, ovf_s;

    // Receive FSM next-state: counter runs from 0 each phase, samples land on its terminal value.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + CNT_W'(1);
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        push_s    = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                // prev_rx_r resets low so a line held low across reset is not taken as a start bit
                if (!rx_i && prev_rx_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CNT_W'(HALF - 1)) begin
                    cnt_s     = '0;
                    bit_idx_s = 3'd0;
                    state_s   = rx_i ? IDLE : DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == CNT_W'(CPB - 1)) begin
                    cnt_s            = '0;
                    shift_s[bit_idx_r] = rx_i;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (cnt_r == CNT_W'(CPB - 1)) begin
                    cnt_s = '0;
                    if (rx_i) begin
                        push_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = WAIT_HIGH;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_HIGH: begin
                cnt_s   = '0;
                state_s = rx_i ? IDLE : WAIT_HIGH;
            end
            default: begin
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; data_s is the head after this cycle's push/pop so data_o can be registered.
    always_comb begin
        pop_s     = valid_r && ready_i;
        full_s    = (count_r == OCC_W'(FIFO_DEPTH));
        push_ok_s = push_s && (!full_s || pop_s);
        ovf_s     = push_s && full_s && !pop_s;
        wr_ptr_s  = push_ok_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        rd_ptr_s  = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + OCC_W'(1);
            2'b01:   count_s = count_r - OCC_W'(1);
            default: count_s = count_r;
        endcase
        if (count_s == OCC_W'(0)) begin
            data_s = 8'h00;
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_s)) begin
            data_s = shift_r;
        end else begin
            data_s = mem_r[rd_ptr_s];
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            prev_rx_r   <= 1'b0;
            frame_err_r <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
            prev_rx_r   <= rx_i;
            frame_err_r <= ferr_s;
            overflow_r  <= ovf_s;
            busy_r      <= (state_s != IDLE);
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            data_r      <= data_s;
            valid_r     <= (count_s != OCC_W'(0));
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= shift_r;
            end
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = frame_err_r;
    assign overflow_o  = overflow_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (5 clocks per bit, half-bit 2).
module tb_uart_rx;

    localparam int CPB  = 5;
    localparam int HALF = 2;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overflow_o, busy_o;

    uart_rx dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .rx_i       (rx),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready),
        .frame_err_o(frame_err_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] popped[$];
    int         ferr_cnt = 0, ovf_cnt = 0, both_cnt = 0;
    bit         valid_seen = 1'b0;
    int         valid_cyc = 0;
    int         last_t0 = 0;

    // Observe outputs mid-cycle: accepted bytes, pulse counts, first valid edge.
    always @(negedge clk) begin
        if (arstn) begin
            if (valid_o && ready) popped.push_back(data_o);
            if (frame_err_o) ferr_cnt++;
            if (overflow_o) ovf_cnt++;
            if (frame_err_o && overflow_o) both_cnt++;
            if (valid_o && !valid_seen) begin
                valid_seen = 1'b1;
                valid_cyc  = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        popped.delete();
        ferr_cnt   = 0;
        ovf_cnt    = 0;
        valid_seen = 1'b0;
    endtask

    // Drive one frame cycle by cycle; j counts edges from t0. ready rises before edge ready_at.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len, input int ready_at);
        int j = 0;
        for (int b = 0; b < 10; b++) begin
            logic v;
            int   len;
            v   = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            len = (b == 9) ? stop_len : CPB;
            for (int c = 0; c < len; c++) begin
                if (j == 0) last_t0 = cyc + 1;
                if (j == ready_at) ready = 1'b1;
                rx = v;
                tick();
                j++;
            end
        end
    endtask

    function automatic logic [8:0] head_or_none(input int idx);
        return (popped.size() > idx) ? {1'b0, popped[idx]} : 9'h100;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        int         exp_ferr;
    } vec_t;
    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h6D, 1'b0, 1'b0, 1};

        // Reset state
        repeat (3) tick();
        check("rst_data", data_o, 8'h00);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        arstn = 1'b1;
        repeat (3) tick();

        // Frame 0xA5 with t0 at edge 100: byte visible in the cycle after edge 147
        clear_mon();
        while (cyc < 99) tick();
        send_frame(8'hA5, 1'b1, CPB, -1);
        repeat (3) tick();
        check("a5_t0", last_t0, 100);
        check("a5_valid_edge", valid_cyc, 147);
        check("a5_data", data_o, 8'hA5);
        check("a5_valid", valid_o, 1'b1);
        check("a5_ferr", ferr_cnt, 0);
        check("a5_ovf", ovf_cnt, 0);
        ready = 1'b1;
        repeat (2) tick();
        ready = 1'b0;
        check("a5_pop", head_or_none(0), 9'h0A5);
        check("a5_empty", valid_o, 1'b0);

        // Start glitch of two cycles
        clear_mon();
        rx = 1'b0;
        tick();
        check("glitch_busy", busy_o, 1'b1);
        tick();
        rx = 1'b1;
        repeat (10) tick();
        check("glitch_valid", valid_seen, 1'b0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_idle", busy_o, 1'b0);

        // Table of single frames with ready held high
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            send_frame(vecs[i].data, vecs[i].stop, CPB, -1);
            rx = 1'b1;
            repeat (2 * CPB) tick();
            check("vec_byte", head_or_none(0), vecs[i].exp_push ? {1'b0, vecs[i].data} : 9'h100);
            check("vec_count", popped.size(), vecs[i].exp_push ? 1 : 0);
            check("vec_ferr", ferr_cnt, vecs[i].exp_ferr);
            check("vec_busy", busy_o, 1'b0);
        end

        // Frame error with the line held low for 20 bit-times
        clear_mon();
        send_frame(8'h3C, 1'b0, CPB, -1);
        repeat (20 * CPB) tick();
        check("brk_ferr", ferr_cnt, 1);
        check("brk_busy", busy_o, 1'b1);
        check("brk_nopush", valid_seen, 1'b0);
        check("brk_ovf", ovf_cnt, 0);
        rx = 1'b1;
        tick();
        check("brk_release", busy_o, 1'b0);
        repeat (CPB) tick();

        // Overflow: five back-to-back bytes with ready low
        clear_mon();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, HALF + 1, -1);
        rx = 1'b1;
        repeat (CPB) tick();
        check("ovf_cnt", ovf_cnt, 1);
        check("ovf_ferr", ferr_cnt, 0);
        check("ovf_head", data_o, 8'h01);
        ready = 1'b1;
        repeat (6) tick();
        ready = 1'b0;
        check("ovf_npop", popped.size(), 4);
        for (int i = 0; i < 4; i++) check("ovf_order", head_or_none(i), 9'(i + 1));
        check("ovf_empty", valid_o, 1'b0);

        // Full FIFO with a pop on the same edge as the fifth push
        clear_mon();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, HALF + 1, -1);
        send_frame(8'h05, 1'b1, CPB, 9 * CPB + HALF);
        repeat (8) tick();
        ready = 1'b0;
        check("coin_ovf", ovf_cnt, 0);
        check("coin_npop", popped.size(), 5);
        for (int i = 0; i < 5; i++) check("coin_order", head_or_none(i), 9'(i + 1));

        // Reset during bit 4 of a frame, line still low on release
        clear_mon();
        send_frame(8'h55, 1'b1, CPB, -1);
        check("pre_rst_data", data_o, 8'h55);
        rx = 1'b0;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (4 * CPB) tick();
        rx = 1'b0;
        repeat (2) tick();
        #2 arstn = 1'b0;
        #1;
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_data", data_o, 8'h00);
        check("mid_rst_busy", busy_o, 1'b0);
        repeat (2) tick();
        arstn = 1'b1;
        repeat (2 * CPB) tick();
        check("post_rst_idle", busy_o, 1'b0);
        rx = 1'b1;
        repeat (CPB) tick();
        ready = 1'b1;
        send_frame(8'h7E, 1'b1, CPB, -1);
        repeat (CPB) tick();
        check("post_rst_byte", head_or_none(0), 9'h07E);
        check("post_rst_count", popped.size(), 1);
        check("post_rst_ferr", ferr_cnt, 0);
        check("post_rst_ovf", ovf_cnt, 0);
        check("err_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz SHALL be provided.
REQ-002 Parameter BAUD_RATE, default 10_000_000, serial bit rate in bit/s SHALL be provided.
REQ-003 Parameter FIFO_DEPTH, default 4, receive buffer entries (power of two, >=2) SHALL be provided.
REQ-004 Port clk_i  input  1  system clock, all logic on rising edge SHALL be provided.
REQ-005 Port arstn_i  input  1  reset, asynchronous, active-low SHALL be provided.
REQ-006 Port rx_i  input  1  serial line, already synchronized to clk_i by the caller, idle high SHALL be provided.
REQ-007 Port data_o  output  8  received byte at FIFO head SHALL be provided.
REQ-008 Port valid_o  output  1  FIFO non-empty, data_o valid SHALL be provided.
REQ-009 Port ready_i  input  1  consumer accepts data_o SHALL be provided.
REQ-010 Port frame_err_o  output  1  one-cycle pulse, stop bit sampled low SHALL be provided.
REQ-011 Port overflow_o  output  1  one-cycle pulse, good byte dropped because FIFO full SHALL be provided.
REQ-012 Port busy_o  output  1  FSM not in IDLE SHALL be provided.

Function
REQ-013 CPB = CLK_FREQ/BAUD_RATE (integer division), HALF = CPB/2; the bit counter SHALL be wide enough for CPB-1; CPB<2 SHALL be flagged by an elaboration-time assertion.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; frame format SHALL be 8N1, LSB first.
REQ-015 IDLE: rx_i sampled 0 at cycle t0 -> START, cycle counter cleared; otherwise remain.
REQ-016 START: rx_i sampled at t0+HALF; 1 -> IDLE (glitch, nothing reported); 0 -> DATA, bit index 0, counter cleared.
REQ-017 DATA: bit k (k=0..7) SHALL be sampled at t0+HALF+(k+1)*CPB into shift register position k; after bit 7 -> STOP.
REQ-018 STOP: rx_i sampled at t0+HALF+9*CPB; 1 -> push byte, -> IDLE; 0 -> frame_err_o pulse next cycle, byte discarded, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_i sampled 1, then -> IDLE; no start detection while in WAIT_HIGH (break condition tolerated).
REQ-020 Push occurs on the cycle after the stop sample; valid_o SHALL be high from that push cycle if FIFO was empty, i.e. byte visible at t0+HALF+9*CPB+1.
REQ-021 FIFO: pop when valid_o && ready_i; data_o SHALL be the oldest entry, stable while valid_o && !ready_i.
REQ-022 Push while full and no pop same cycle -> byte dropped, overflow_o pulse, FIFO contents unchanged.
REQ-023 Push while full with pop same cycle -> push accepted, no overflow, occupancy unchanged.
REQ-024 Push and pop same cycle when non-full non-empty -> occupancy unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Pop when empty SHALL be ignored (ready_i is don't-care while valid_o low).
REQ-026 Next-frame start bit SHALL be detectable on the first cycle after return to IDLE (back-to-back frames).
REQ-027 frame_err_o and overflow_o SHALL never be asserted in the same cycle.

Reset
REQ-028 arstn_i low SHALL immediately force: FSM IDLE, counters 0, shift register 0, FIFO empty (pointers 0), valid_o 0, data_o 0, frame_err_o 0, overflow_o 0, busy_o 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release, reception restarts only on a new falling edge of rx_i, with no error pulse.

Verification
REQ-030 Defaults, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with t0 at cycle 100 -> valid_o rises at cycle 148, data_o=0xA5, no error pulses.
REQ-031 rx_i low for 2 cycles only then high -> returns to IDLE, valid_o stays 0, frame_err_o stays 0.
REQ-032 Frame 0x3C with stop bit low, line low for 20 further bit-times -> one frame_err_o pulse, no push, busy_o high until rx_i returns high.
REQ-033 ready_i=0, send 5 back-to-back bytes 0x01..0x05 -> FIFO holds 0x01..0x04, one overflow_o pulse on the 5th; then ready_i=1 -> pops 0x01,0x02,0x03,0x04 in order.
REQ-034 FIFO full, ready_i=1 held so a pop coincides with the 5th push -> no overflow_o, output sequence 0x01..0x05.
REQ-035 arstn_i pulsed low during bit 4 of a frame -> all outputs 0 immediately; next clean frame 0x7E received correctly.
